// File: rtl/apb_adc_capture_if.sv
// APB completer-side bus bundle for apb_adc_capture (word address PADDR[11:2]).
interface apb_adc_capture_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [11:2] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
   modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/apb_adc_capture.sv
// Multi-channel APB ADC capture: per-channel holding registers with full/overrun flags and enable mask.
// Optional tagged-sample FIFO at words 0x43/0x44 when ADC_FIFO_EN is defined.
module apb_adc_capture #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned ADC_W      = 12,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   apb_adc_capture_if.slave        bus,
   input  logic [NUM_CH*ADC_W-1:0] ADC_DATA,
   input  logic [NUM_CH-1:0]       ADC_VALID,
   output logic                    ADC_IRQ
);

   localparam logic [9:0] A_STATUS    = 10'h040;
   localparam logic [9:0] A_CTRL      = 10'h041;
   localparam logic [9:0] A_CLR       = 10'h042;
   localparam logic [9:0] A_FIFO      = 10'h043;
   localparam logic [9:0] A_FIFO_STAT = 10'h044;

   logic              rd;
   logic              wr;
   logic [9:0]        word;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] ovr;
   logic [NUM_CH-1:0] cap;
   logic [NUM_CH-1:0] data_rd;
   logic [ADC_W-1:0]  sample [NUM_CH];
   logic [31:0]       prdata;
   logic              unused_pwdata;

   assign word          = bus.PADDR;
   assign rd            = bus.PSEL & bus.PENABLE & ~bus.PWRITE;
   assign wr            = bus.PSEL & bus.PENABLE & bus.PWRITE;
   assign cap           = ADC_VALID & en;
   assign bus.PREADY    = 1'b1;
   assign bus.PRDATA    = prdata;
   assign unused_pwdata = ^bus.PWDATA;

   // Per-channel DATA register read strobes
   always_comb begin
      data_rd = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         data_rd[n] = rd && (word == 10'(n));
      end
   end

   // Enable mask resets to all ones
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         en <= '1;
      end else if (wr && word == A_CTRL) begin
         en <= bus.PWDATA[NUM_CH-1:0];
      end
   end

   // Holding registers; a capture coinciding with a read keeps full set without overrun
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         full <= '0;
         ovr  <= '0;
         for (int n = 0; n < NUM_CH; n++) sample[n] <= '0;
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (cap[n]) begin
               sample[n] <= ADC_DATA[n*ADC_W +: ADC_W];
               full[n]   <= 1'b1;
            end else if (data_rd[n]) begin
               full[n]   <= 1'b0;
            end
            if (cap[n] && full[n] && !data_rd[n]) begin
               ovr[n] <= 1'b1;
            end else if (wr && word == A_CLR && bus.PWDATA[16+n]) begin
               ovr[n] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) ADC_IRQ <= 1'b0;
      else          ADC_IRQ <= |(full & en);
   end

`ifdef ADC_FIFO_EN
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [19:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             drop;
   logic             fifo_full;
   logic             push_req;
   logic             push_ok;
   logic             pop;
   logic             multi;
   logic [3:0]       push_ch;
   logic [15:0]      push_smp;

   // Lowest-index accepted channel wins the single push slot
   always_comb begin
      push_ch  = '0;
      push_smp = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cap[i]) begin
            push_ch  = 4'(i);
            push_smp = 16'(ADC_DATA[i*ADC_W +: ADC_W]);
         end
      end
   end

   assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
   assign push_req  = |cap;
   assign multi     = |(cap & (cap - NUM_CH'(1)));
   assign pop       = rd && (word == A_FIFO) && (count != '0);
   assign push_ok   = push_req && (!fifo_full || pop);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         drop   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {push_ch, push_smp};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop)      count <= count + CNT_W'(1);
         else if (!push_ok && pop) count <= count - CNT_W'(1);
         if (multi || (push_req && !push_ok))               drop <= 1'b1;
         else if (wr && word == A_CLR && bus.PWDATA[31])    drop <= 1'b0;
      end
   end
`endif

   // Read mux; valid throughout the access phase
   always_comb begin
      prdata = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (word == 10'(n)) prdata = {full[n], ovr[n], 30'(sample[n])};
      end
      case (word)
         A_STATUS: prdata = 32'(full) | (32'(ovr) << 16);
         A_CTRL:   prdata = 32'(en);
`ifdef ADC_FIFO_EN
         A_FIFO:      prdata = (count != '0) ?
                               {1'b1, 3'b0, mem[rd_ptr][19:16], 8'b0, mem[rd_ptr][15:0]} : 32'b0;
         A_FIFO_STAT: prdata = {14'b0, drop, fifo_full, 7'b0, 9'(count)};
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_apb_adc_capture.sv
// Directed self-checking bench for apb_adc_capture (NUM_CH=4, ADC_W=12, FIFO_DEPTH=8).
module tb_apb_adc_capture;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned ADC_W  = 12;

   logic                    PCLK;
   logic                    PRESETn;
   logic [NUM_CH*ADC_W-1:0] ADC_DATA;
   logic [NUM_CH-1:0]       ADC_VALID;
   logic                    ADC_IRQ;
   logic [31:0]             rdata;
   int                      n_checks;
   int                      n_fail;

   apb_adc_capture_if bus ();

   apb_adc_capture #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .FIFO_DEPTH(8)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus),
      .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID), .ADC_IRQ(ADC_IRQ)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_CH*ADC_W-1:0] slot(input int ch, input logic [ADC_W-1:0] v);
      logic [NUM_CH*ADC_W-1:0] d;
      d = '0;
      d[ch*ADC_W +: ADC_W] = v;
      return d;
   endfunction

   task automatic strobe(input logic [NUM_CH-1:0] vld, input logic [NUM_CH*ADC_W-1:0] dat);
      @(posedge PCLK); #1;
      ADC_VALID = vld;
      ADC_DATA  = dat;
      @(posedge PCLK); #1;
      ADC_VALID = '0;
   endtask

   // Optional strobe is presented together with the access phase
   task automatic apb_read(input logic [9:0] addr, output logic [31:0] data,
                           input logic [NUM_CH-1:0] vld, input logic [NUM_CH*ADC_W-1:0] dat);
      @(posedge PCLK); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1; ADC_VALID = vld; ADC_DATA = dat;
      #2 data = bus.PRDATA;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; ADC_VALID = '0;
   endtask

   task automatic apb_write(input logic [9:0] addr, input logic [31:0] data,
                            input logic [NUM_CH-1:0] vld, input logic [NUM_CH*ADC_W-1:0] dat);
      @(posedge PCLK); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = addr; bus.PWDATA = data;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1; ADC_VALID = vld; ADC_DATA = dat;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; ADC_VALID = '0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      PRESETn = 1'b0; ADC_DATA = '0; ADC_VALID = '0;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b1;

      check("rst_irq", 32'(ADC_IRQ), 32'h0);
      apb_read(10'h041, rdata, '0, '0); check("rst_ctrl", rdata, 32'h0000000F);
      apb_read(10'h040, rdata, '0, '0); check("rst_status", rdata, 32'h0);

      // single capture, read consumes it
      strobe(4'b0010, slot(1, 12'hABC));
      apb_read(10'h040, rdata, '0, '0); check("ch1_status", rdata, 32'h00000002);
      check("ch1_irq", 32'(ADC_IRQ), 32'h1);
      apb_read(10'h001, rdata, '0, '0); check("ch1_data", rdata, 32'h80000ABC);
      check("irq_hold", 32'(ADC_IRQ), 32'h1);
      @(posedge PCLK); #1;
      check("irq_fall", 32'(ADC_IRQ), 32'h0);
      apb_read(10'h040, rdata, '0, '0); check("ch1_status_clr", rdata, 32'h0);

      // overrun then W1C clear
      strobe(4'b0001, slot(0, 12'h111));
      strobe(4'b0001, slot(0, 12'h222));
      apb_read(10'h000, rdata, '0, '0); check("ch0_ovr_data", rdata, 32'hC0000222);
      apb_read(10'h040, rdata, '0, '0); check("ch0_ovr_status", rdata, 32'h00010000);
      apb_write(10'h042, 32'h00010000, '0, '0);
      apb_read(10'h040, rdata, '0, '0); check("ch0_clr_status", rdata, 32'h0);
      apb_read(10'h042, rdata, '0, '0); check("clr_reads0", rdata, 32'h0);

      // capture coincident with read
      strobe(4'b0100, slot(2, 12'h005));
      apb_read(10'h002, rdata, 4'b0100, slot(2, 12'h7FF)); check("ch2_old", rdata, 32'h80000005);
      apb_read(10'h002, rdata, '0, '0); check("ch2_new", rdata, 32'h800007FF);
      apb_read(10'h040, rdata, '0, '0); check("ch2_no_ovr", rdata, 32'h0);

      // disabled channel ignores strobe
      strobe(4'b1000, slot(3, 12'h123));
      apb_read(10'h003, rdata, '0, '0); check("ch3_first", rdata, 32'h80000123);
      apb_write(10'h041, 32'h1, '0, '0);
      apb_read(10'h041, rdata, '0, '0); check("ctrl_wr", rdata, 32'h1);
      strobe(4'b1000, slot(3, 12'h3FF));
      apb_read(10'h040, rdata, '0, '0); check("ch3_dis_status", rdata, 32'h0);
      check("ch3_dis_irq", 32'(ADC_IRQ), 32'h0);
      apb_read(10'h003, rdata, '0, '0); check("ch3_dis_data", rdata, 32'h00000123);
      apb_write(10'h041, 32'hF, '0, '0);

      apb_read(10'h010, rdata, '0, '0); check("unmapped", rdata, 32'h0);

      // clear racing a new overrun: set wins
      strobe(4'b0001, slot(0, 12'h001));
      strobe(4'b0001, slot(0, 12'h002));
      apb_write(10'h042, 32'h00010000, 4'b0001, slot(0, 12'h003));
      apb_read(10'h040, rdata, '0, '0); check("set_wins", rdata, 32'h00010001);
      apb_read(10'h000, rdata, '0, '0); check("set_wins_data", rdata, 32'hC0000003);
      apb_write(10'h042, 32'h00010000, '0, '0);
      apb_read(10'h040, rdata, '0, '0); check("set_wins_clr", rdata, 32'h0);

      // reset mid-operation
      strobe(4'b0100, slot(2, 12'h456));
      apb_write(10'h041, 32'h4, '0, '0);
      @(posedge PCLK); #1 PRESETn = 1'b0;
      @(posedge PCLK); #1 PRESETn = 1'b1;
      check("mid_rst_irq", 32'(ADC_IRQ), 32'h0);
      apb_read(10'h040, rdata, '0, '0); check("mid_rst_status", rdata, 32'h0);
      apb_read(10'h041, rdata, '0, '0); check("mid_rst_ctrl", rdata, 32'hF);
      apb_read(10'h002, rdata, '0, '0); check("mid_rst_data", rdata, 32'h0);

`ifdef ADC_FIFO_EN
      for (int i = 0; i < 9; i++) strobe(4'b0010, slot(1, 12'(i + 1)));
      apb_read(10'h044, rdata, '0, '0); check("fifo_stat_full", rdata, 32'h00030008);
      for (int i = 0; i < 8; i++) begin
         apb_read(10'h043, rdata, '0, '0);
         check($sformatf("fifo_pop%0d", i), rdata, 32'h81000000 | 32'(i + 1));
      end
      apb_read(10'h043, rdata, '0, '0); check("fifo_empty_pop", rdata, 32'h0);
      apb_read(10'h044, rdata, '0, '0); check("fifo_stat_empty", rdata, 32'h00020000);
      apb_write(10'h042, 32'h80000000, '0, '0);
      apb_read(10'h044, rdata, '0, '0); check("fifo_drop_clr", rdata, 32'h0);
      strobe(4'b0110, slot(1, 12'h012) | slot(2, 12'h034));
      apb_read(10'h044, rdata, '0, '0); check("fifo_multi_stat", rdata, 32'h00020001);
      apb_read(10'h043, rdata, '0, '0); check("fifo_multi_pop", rdata, 32'h81000012);
`else
      strobe(4'b0010, slot(1, 12'h055));
      apb_read(10'h043, rdata, '0, '0); check("nofifo_word43", rdata, 32'h0);
      apb_read(10'h044, rdata, '0, '0); check("nofifo_word44", rdata, 32'h0);
`endif

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule

// File: doc/apb_adc_capture.md
Name: apb_adc_capture

Overview:
Parametrised multi-channel successor of the single-channel APB ADC read bridge. Captures per-channel ADC samples into holding registers with full and sticky-overrun flags, a channel-enable mask and status registers. A software read of a channel's data register consumes that channel's sample. Sits on the peripheral APB between the ADC front-end sample strobes and the PID control firmware.

Parameters:
NUM_CH, 4, number of ADC channels (1..16)
ADC_W, 12, sample width in bits (1..16)
FIFO_DEPTH, 8, entries in the optional tagged-sample FIFO (power of 2, 2..256; unused without ADC_FIFO_EN)

Ports:
PCLK  in  1  APB clock; the only clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB peripheral select
PENABLE  in  1  APB enable (access phase)
PWRITE  in  1  APB write=1 / read=0
PADDR  in  [11:2]  APB word address
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data, combinational from PADDR, valid in access phase
PREADY  out  1  tied 1 (zero wait states)
ADC_DATA  in  NUM_CH*ADC_W  packed samples; channel n at [n*ADC_W +: ADC_W]
ADC_VALID  in  NUM_CH  per-channel one-cycle sample strobe
ADC_IRQ  out  1  registered; high while any enabled channel is full

Behaviour:
- Clock and reset: one clock PCLK; reset PRESETn asynchronous, active-low. All flops clear on reset except CTRL.EN, which resets to all ones. ADC_IRQ=0 after reset.
- rd = PSEL&PENABLE&~PWRITE; wr = PSEL&PENABLE&PWRITE. Each access takes effect once, on the access-phase edge.
- Address map (word index = PADDR[11:2]):
  - 0..NUM_CH-1: DATA[n]
  - 0x40: STATUS
  - 0x41: CTRL
  - 0x42: CLR
  - 0x43: FIFO
  - 0x44: FIFO_STAT
  - Unmapped reads return 0; unmapped and read-only writes are ignored.
- DATA[n] read: [ADC_W-1:0]=sample, [30]=ovr[n], [31]=full[n], other bits 0. A read clears full[n] on that edge.
- STATUS read: [NUM_CH-1:0]=full, [16+NUM_CH-1:16]=ovr.
- CTRL read/write: [NUM_CH-1:0]=EN mask. A change takes effect from the next cycle.
- CLR write (W1C): PWDATA[16+n] clears ovr[n]. Reads return 0.
- Capture, per channel, when ADC_VALID[n]&EN[n]:
  - sample[n]<=ADC_DATA slice and full[n]<=1, one-cycle latency.
  - If full[n] was already 1 and the channel is not being read this cycle, the sample is still overwritten and ovr[n]<=1.
- Disabled channel: the strobe is ignored; held sample and flags are retained.
- Simultaneous capture and DATA[n] read: PRDATA returns the old sample; the new sample is stored; full[n] stays 1; no overrun.
- Simultaneous CLR and a new overrun on the same channel: set wins, ovr stays 1.
- ADC_IRQ <= |(full & EN), registered.
- Reset mid-operation: all samples and flags are lost; the FIFO empties.

Optional Feature:
- Macro ADC_FIFO_EN.
- Defined:
  - Each cycle, the lowest-index accepted sample is pushed as {1'b1, 3'b0, ch[3:0], 8'b0, zero-extended sample[15:0]}.
  - Other samples accepted in the same cycle, and any push while the FIFO is full, are not stored and set sticky drop.
  - FIFO read: pops when non-empty and returns the head with [31]=1. When empty it returns 0 and the pointers are unchanged.
  - Simultaneous push and pop when full: the pop happens and the push is accepted.
  - FIFO_STAT: [8:0]=count, [16]=full, [17]=drop.
  - CLR PWDATA[31] clears drop.
  - Holding registers behave identically to the build without the FIFO.
- Undefined: no FIFO logic; words 0x43 and 0x44 read 0.

Test Plan:
- Reset, then read CTRL=0x0000000F, STATUS=0, ADC_IRQ=0.
- ADC_VALID=4'b0010 with ch1=0xABC -> one cycle later STATUS=0x00000002, IRQ=1. Read DATA[1]=0x80000ABC, then STATUS=0 and IRQ falls the following cycle.
- Two ch0 strobes (0x111 then 0x222) with no read -> DATA[0]=0xC0000222. CLR write 0x00010000 -> STATUS bit16=0.
- Strobe ch2 in the same cycle as a DATA[2] read (old 0x005, new 0x7FF) -> PRDATA=0x80000005; next read returns 0x800007FF; ovr[2]=0.
- CTRL=0x1, strobe ch3=0x3FF -> full[3] stays 0, DATA[3] keeps its prior value, IRQ unaffected.
- ADC_FIFO_EN, DEPTH=8: 9 single-channel pushes -> count=8, full=1, drop=1. 8 FIFO reads return the first 8 samples in order with correct tags; the 9th read returns 0.
